// File: rtl/ckp_wheel_gen.sv
// rtl/ckp_wheel_gen.sv - crank trigger-wheel (missing-tooth CKP) waveform generator
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous reset, active low
//   enable       run request, level sensitive, acted on at slot boundaries
//   tooth_period clocks per tooth slot, clamped to >= 4, sampled at slot start
//   ckp          generated crank signal, idle high
//   tooth_index  current slot, 0 = first real tooth after the gap
//   sync         pulse on the first clock of slot 0
//   rev_done     pulse on the last clock of slot NUM_TEETH-1
//   rev_count    completed revolutions, wrapping
//   busy         high whenever the generator is not idle
module ckp_wheel_gen #(
  parameter int NUM_TEETH     = 36,
  parameter int MISSING_TEETH = 1,
  parameter int PERIOD_WIDTH  = 24,
  parameter int REV_WIDTH     = 16,
  localparam int IDX_W        = $clog2(NUM_TEETH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] tooth_period,
  output logic                    ckp,
  output logic [IDX_W-1:0]        tooth_index,
  output logic                    sync,
  output logic                    rev_done,
  output logic [REV_WIDTH-1:0]    rev_count,
  output logic                    busy
);

  localparam logic [IDX_W-1:0]        LAST_IDX      = IDX_W'(NUM_TEETH - 1);
  localparam logic [IDX_W-1:0]        FIRST_MISSING = IDX_W'(NUM_TEETH - MISSING_TEETH);
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD    = PERIOD_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t                  state, state_n;
  logic [PERIOD_WIDTH-1:0] cnt, cnt_n;
  logic [PERIOD_WIDTH-1:0] per, per_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [PERIOD_WIDTH-1:0] p_in;
  logic [PERIOD_WIDTH-1:0] low_len;
  logic [IDX_W-1:0]        idx_next;
  logic                    slot_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      per       <= '0;
      idx       <= '0;
      rev_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      per   <= per_n;
      idx   <= idx_n;
      if (rev_done) begin
        rev_count <= rev_count + REV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    p_in     = (tooth_period < MIN_PERIOD) ? MIN_PERIOD : tooth_period;
    low_len  = per >> 1;
    slot_end = (state != S_IDLE) && (cnt == per - PERIOD_WIDTH'(1));
    idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);

    state_n = state;
    cnt_n   = cnt + PERIOD_WIDTH'(1);
    per_n   = per;
    idx_n   = idx;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (enable) begin
          state_n = S_LOW;
          idx_n   = '0;
          per_n   = p_in;
        end
      end
      S_LOW: begin
        // low_len >= 2 because per >= 4, so a LOW phase never ends a slot
        if (cnt == low_len - PERIOD_WIDTH'(1)) begin
          state_n = S_HIGH;
        end
      end
      default: begin
        if (slot_end) begin
          cnt_n = '0;
          if (!enable) begin
            state_n = S_IDLE;
            idx_n   = '0;
          end else begin
            idx_n   = idx_next;
            per_n   = p_in;
            state_n = (idx_next >= FIRST_MISSING) ? S_GAP : S_LOW;
          end
        end
      end
    endcase
  end

  // Pure decodes of registered state: ckp returns high asynchronously on reset.
  assign ckp         = (state != S_LOW);
  assign busy        = (state != S_IDLE);
  assign tooth_index = idx;
  assign sync        = busy && (idx == '0) && (cnt == '0);
  assign rev_done    = slot_end && (idx == LAST_IDX);

endmodule

// File: tb/tb_ckp_wheel_gen.sv
// tb/tb_ckp_wheel_gen.sv - scoreboard bench for ckp_wheel_gen against a slot-level model
module tb_ckp_wheel_gen;

  localparam int N  = 36;
  localparam int M  = 1;
  localparam int PW = 24;
  localparam int RW = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [PW-1:0] tooth_period;
  logic          ckp;
  logic [IW-1:0] tooth_index;
  logic          sync;
  logic          rev_done;
  logic [RW-1:0] rev_count;
  logic          busy;

  int checks = 0;
  int failures = 0;

  ckp_wheel_gen #(
    .NUM_TEETH(N), .MISSING_TEETH(M), .PERIOD_WIDTH(PW), .REV_WIDTH(RW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tooth_period(tooth_period),
    .ckp(ckp), .tooth_index(tooth_index), .sync(sync), .rev_done(rev_done),
    .rev_count(rev_count), .busy(busy)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic          ckp;
    logic [IW-1:0] idx;
    logic          sync;
    logic          rd;
    logic [RW-1:0] rc;
    logic          busy;
  } rec_t;

  rec_t plan[$];
  rec_t sb[$];
  int            m_next;
  logic [RW-1:0] m_revs;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: expands each whole slot into its per-clock expected outputs
  // the moment the slot starts, then feeds one record per clock to the scoreboard.
  always @(posedge clk or negedge reset_n) begin
    rec_t r;
    int   p;
    if (!reset_n) begin
      plan.delete();
      sb.delete();
      m_revs = '0;
      m_next = 0;
    end else begin
      if (plan.size() == 0) begin
        if (enable) begin
          p = (tooth_period < 4) ? 4 : int'(tooth_period);
          for (int c = 0; c < p; c++) begin
            r.ckp  = (m_next < N - M && c < p / 2) ? 1'b0 : 1'b1;
            r.idx  = IW'(m_next);
            r.sync = (m_next == 0 && c == 0);
            r.rd   = (m_next == N - 1 && c == p - 1);
            r.rc   = m_revs;
            r.busy = 1'b1;
            plan.push_back(r);
          end
          if (m_next == N - 1) begin
            m_revs = m_revs + 1'b1;
            m_next = 0;
          end else begin
            m_next = m_next + 1;
          end
        end else begin
          m_next = 0;
          r.ckp = 1'b1; r.idx = '0; r.sync = 1'b0; r.rd = 1'b0; r.rc = m_revs; r.busy = 1'b0;
          plan.push_back(r);
        end
      end
      sb.push_back(plan.pop_front());
    end
  end

  // Monitor: DUT outputs are valid every clock; compare away from the active edge.
  always @(negedge clk) begin
    rec_t e;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("ckp", ckp, e.ckp);
      check("tooth_index", tooth_index, e.idx);
      check("sync", sync, e.sync);
      check("rev_done", rev_done, e.rd);
      check("rev_count", rev_count, e.rc);
      check("busy", busy, e.busy);
    end
  end

  task automatic wait_slot(input int target, input string name);
    int k;
    k = 0;
    while (!(busy && tooth_index == IW'(target)) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_reached"}, (k < 4000) ? 1 : 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ckp"}, ckp, 1);
    check({tag, "_idx"}, tooth_index, 0);
    check({tag, "_sync"}, sync, 0);
    check({tag, "_rev_done"}, rev_done, 0);
    check({tag, "_rev_count"}, rev_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    tooth_period = PW'(10);
    repeat (3) @(negedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: period 10, one full revolution plus margin
    enable = 1'b1;
    repeat (400) @(negedge clk);
    // 2: period 7
    tooth_period = PW'(7);
    repeat (520) @(negedge clk);
    // 3: below minimum, clamped to 4
    tooth_period = PW'(2);
    repeat (300) @(negedge clk);
    // 4: change 10 -> 20 midway through slot 5
    tooth_period = PW'(10);
    wait_slot(5, "slot5");
    repeat (5) @(negedge clk);
    tooth_period = PW'(20);
    repeat (800) @(negedge clk);
    // 5: stop mid slot 12, then restart
    wait_slot(12, "slot12");
    repeat (7) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    check("stopped_busy", busy, 0);
    check("stopped_idx", tooth_index, 0);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    // random periods and enable toggling
    for (int i = 0; i < 20; i++) begin
      tooth_period = PW'($urandom_range(0, 25));
      enable = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 250)) @(negedge clk);
    end
    // 6: reset in the middle of the gap
    enable = 1'b1;
    tooth_period = PW'(10);
    wait_slot(N - 1, "gap");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midgap_reset");
    @(negedge clk);
    reset_n = 1'b1;
    // rev_count wrap after 2^RW revolutions at P=4 (144 clocks each)
    tooth_period = PW'(4);
    @(negedge clk);
    repeat (16 * 144 + 5) @(negedge clk);
    check("wrap_rev_count", rev_count, 0);
    check("wrap_busy", busy, 1);
    repeat (200) @(negedge clk);
    check("scoreboard_drained", (sb.size() <= 1) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ckp_wheel_gen.md
Name: ckp_wheel_gen

Overview:
Synthesizable crank trigger-wheel generator. Produces the CKP waveform that the hust_efi crank state machine consumes: a toothed wheel with a missing-tooth gap and a programmable tooth period. It is used as the stimulus source in system benches and as an on-chip self-test source, selectable by a mux in front of the real sensor input. Its output drives the same `ckp` net as the sensor.

Parameters:
NUM_TEETH, 36, total tooth slots per revolution, including missing slots (matches CFG_NUM_TEETH).
MISSING_TEETH, 1, number of consecutive missing slots at the end of each revolution (1..NUM_TEETH-2).
PERIOD_WIDTH, 24, width of the tooth-period field in clocks.
REV_WIDTH, 16, width of the revolution counter.

Ports:
clk  input  1  system clock (125 MHz)
reset_n  input  1  asynchronous reset, active low
enable  input  1  run request; level sensitive
tooth_period  input  PERIOD_WIDTH  clocks per tooth slot; sampled at each slot start
ckp  output  1  generated crank signal; idle high
tooth_index  output  $clog2(NUM_TEETH)  current slot, 0 = first real tooth after the gap
sync  output  1  one-cycle pulse on the first clock of slot 0
rev_done  output  1  one-cycle pulse on the last clock of slot NUM_TEETH-1
rev_count  output  REV_WIDTH  completed revolutions; wraps modulo 2^REV_WIDTH
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values (async assert, sync release): ckp=1, tooth_index=0, sync=0, rev_done=0, rev_count=0, busy=0, state=IDLE, internal period latch=0, slot counter=0.
- Period latch: P = max(tooth_period, 4). Latched on the first clock of every slot. A mid-slot change of tooth_period takes effect at the next slot.
- Real slots (index 0..NUM_TEETH-MISSING_TEETH-1):
  - ckp=0 for L=floor(P/2) clocks, then ckp=1 for P-L clocks.
- Missing slots (index NUM_TEETH-MISSING_TEETH..NUM_TEETH-1): ckp=1 for all P clocks.
- States:
  - IDLE: ckp=1. On enable=1, go to LOW with index 0. sync asserts on that first LOW clock, so ckp falls one clock after enable is sampled.
  - LOW: ckp=0. After L clocks, go to HIGH.
  - HIGH: ckp=1. At the end of the slot:
    - if the next index is a real tooth, go to LOW;
    - if it is a missing slot, go to GAP;
    - if the slot just finished was NUM_TEETH-1, wrap to 0 and go to LOW.
  - GAP: ckp=1 for P clocks. At the end of the slot, go to GAP or LOW by the same rule.
- Revolution length = the sum of the P values latched over NUM_TEETH slots (NUM_TEETH*P when P is constant).
- rev_done pulses on the final clock of slot NUM_TEETH-1. rev_count increments on that same edge.
- tooth_index updates on the first clock of each slot.
- Stop: enable=0 is checked only at slot end.
  - The current slot always completes; then the block goes to IDLE (ckp=1) and index returns to 0.
  - rev_count is retained.
  - If the stop lands at the end of slot NUM_TEETH-1, rev_done still pulses and rev_count increments.
- Restart always begins at slot 0 with sync, so there is no partial revolution after a restart.
- Simultaneous events: enable falling on the same clock a slot ends counts as stop at that slot end.
- Reset mid-slot: all outputs return to reset values immediately, with ckp=1 asynchronously.
- The slot counter is PERIOD_WIDTH bits and counts 0..P-1. No overflow is possible because P ≤ 2^PERIOD_WIDTH-1.

Test Plan:
1. Reset, then enable=1 with tooth_period=10 (NUM_TEETH=36, MISSING=1) -> ckp falls 1 clock after enable sampled, sync=1 for that clock, ckp low 5 / high 5 per tooth for 35 teeth, then high 10 clocks in the gap; rev_done on clock 360; rev_count=1.
2. tooth_period=7 -> low 3, high 4 per tooth, gap 7 high; revolution = 252 clocks; sync every 252 clocks; rev_count increments once per revolution.
3. tooth_period=2 (below minimum) -> clamped to P=4: low 2 / high 2, revolution 144 clocks.
4. tooth_period changed 10->20 midway through slot 5 -> slot 5 stays 10 clocks; slot 6 onward is low 10 / high 10; no glitch on ckp.
5. enable dropped mid slot 12 -> slot 12 completes, then IDLE with ckp=1, busy=0, tooth_index=0, rev_count unchanged; re-enable -> sync asserts and the sequence restarts at slot 0.
6. reset_n asserted in the middle of the gap -> ckp=1, all counters 0 immediately. rev_count wrap: preload via 2^REV_WIDTH revolutions (REV_WIDTH=4, 16 revs) -> rev_count returns to 0.
